issue_scheduler: RTL and testbench

- Sits between Decode and the execute stage and sequences instruction issue.
- Holds a 32-entry register scoreboard and an outstanding-writer counter, and drives Decode's stall and kill.
- Issues decoded_inst0 only when its source and destination registers are free and execute can accept it.
- Runs a flush FSM on control-flow redirects, asserting kill for a fixed number of cycles.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/operand_usage.sv | 40 ++++
 rtl/issue_scheduler.sv | 134 +++++++++++++
 tb/tb_issue_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, decoded-instruction layout, scheduler states.
package pipeline_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned XLEN     = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } decoded_inst_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_t;

endpackage

// File: rtl/operand_usage.sv
// Maps an opcode to the register operands it reads and writes.
//   i_opcode      : 7-bit major opcode
//   o_use_rs1_c   : instruction reads rs1
//   o_use_rs2_c   : instruction reads rs2
//   o_use_rd_c    : instruction writes rd
module operand_usage
    import pipeline_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_use_rs1_c,
    output logic       o_use_rs2_c,
    output logic       o_use_rd_c
);

    always_comb begin
        o_use_rs1_c = 1'b0;
        o_use_rs2_c = 1'b0;
        o_use_rd_c  = 1'b0;
        case (i_opcode)
            OP: begin
                o_use_rs1_c = 1'b1;
                o_use_rs2_c = 1'b1;
                o_use_rd_c  = 1'b1;
            end
            LOAD, OP_IMM, JALR: begin
                o_use_rs1_c = 1'b1;
                o_use_rd_c  = 1'b1;
            end
            STORE, BRANCH: begin
                o_use_rs1_c = 1'b1;
                o_use_rs2_c = 1'b1;
            end
            LUI, JAL: begin
                o_use_rd_c  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler between Decode and Execute: register scoreboard, outstanding-writer
// limit, and a redirect flush sequencer driving Decode's stall/kill.
//   clk, reset (async, active-high)
//   dec_valid, decoded_inst0, decoded_inst0_pc : candidate instruction from Decode
//   ex_ready                                   : execute can accept this cycle
//   wb_valid, wb_rd                            : register writeback retirement
//   redirect_valid                             : control-flow redirect from execute
//   stall, kill                                : flow control back to Decode/Fetch
//   issue_valid, issue_inst, issue_pc          : issued instruction to execute
//   sb_busy                                    : scoreboard busy vector (debug)
module issue_scheduler
    import pipeline_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES    = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [63:0]         decoded_inst0,
    input  logic [XLEN-1:0]     decoded_inst0_pc,
    input  logic                ex_ready,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic                redirect_valid,
    output logic                stall,
    output logic                kill,
    output logic                issue_valid,
    output logic [63:0]         issue_inst,
    output logic [XLEN-1:0]     issue_pc,
    output logic [NUM_REGS-1:0] sb_busy
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FC_W  = 4;

    decoded_inst_t       w_inst;
    logic                w_use_rs1;
    logic                w_use_rs2;
    logic                w_use_rd;
    logic [NUM_REGS-1:0] w_wb_mask;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic [NUM_REGS-1:0] w_set_mask;
    logic                w_hazard;
    logic                w_writes_rd;
    logic                w_full;
    logic                w_issue;
    logic                w_inc;

    logic [NUM_REGS-1:0] r_sb;
    logic [CNT_W-1:0]    r_count;
    sched_state_t        r_state;
    logic [FC_W-1:0]     r_flush_cnt;
    logic                r_kill;

    assign w_inst = decoded_inst_t'(decoded_inst0);

    operand_usage u_operand_usage (
        .i_opcode    (w_inst.opcode),
        .o_use_rs1_c (w_use_rs1),
        .o_use_rs2_c (w_use_rs2),
        .o_use_rd_c  (w_use_rd)
    );

    // Same-cycle writeback releases its register (register file writes through).
    assign w_wb_mask  = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
    assign w_busy_eff = r_sb & ~w_wb_mask;

    // x0 is never busy, so no explicit x0 term is needed in the hazard check.
    assign w_hazard = (w_use_rs1 & w_busy_eff[w_inst.rs1])
                    | (w_use_rs2 & w_busy_eff[w_inst.rs2])
                    | (w_use_rd  & w_busy_eff[w_inst.rd]);

    assign w_writes_rd = w_use_rd & (w_inst.rd != 5'd0);
    assign w_full      = w_writes_rd & (r_count == CNT_W'(MAX_OUTSTANDING)) & ~wb_valid;

    assign w_issue = dec_valid & ~w_hazard & ~w_full & ex_ready & ~redirect_valid
                   & (r_state == RUN);
    assign w_inc   = w_issue & w_writes_rd;

    assign w_set_mask = w_inc ? (NUM_REGS'(1) << w_inst.rd) : '0;

    assign issue_valid = w_issue;
    assign issue_inst  = w_inst;
    assign issue_pc    = decoded_inst0_pc;
    assign stall       = (r_state == RUN) & dec_valid & ~w_issue & ~redirect_valid;
    assign kill        = r_kill;
    assign sb_busy     = r_sb;

    // Scoreboard: clear on writeback, then set on issue so set wins a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~w_wb_mask) | w_set_mask;
        end
    end

    // Outstanding writers; underflow saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_inc && !wb_valid) begin
            r_count <= r_count + CNT_W'(1);
        end else if (!w_inc && wb_valid && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Flush sequencer: kill mirrors the FLUSH state, redirect (re)loads the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_kill      <= 1'b0;
        end else if (redirect_valid) begin
            r_state     <= FLUSH;
            r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            r_kill      <= 1'b1;
        end else if (r_state == FLUSH) begin
            if (r_flush_cnt == '0) begin
                r_state <= RUN;
                r_kill  <= 1'b0;
            end else begin
                r_flush_cnt <= r_flush_cnt - FC_W'(1);
            end
        end
    end

    a_wb_underflow: assert property (@(posedge clk) disable iff (reset)
        !(wb_valid && (r_count == '0)));

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic, all checked
// against a queue-based model of outstanding writers and a kill countdown.
module tb_issue_scheduler;
    import pipeline_pkg::*;

    localparam int unsigned FC = 2;
    localparam int unsigned MO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [63:0] decoded_inst0;
    logic [31:0] decoded_inst0_pc;
    logic        ex_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        redirect_valid;
    logic        stall;
    logic        kill;
    logic        issue_valid;
    logic [63:0] issue_inst;
    logic [31:0] issue_pc;
    logic [31:0] sb_busy;

    always #5 clk = ~clk;

    issue_scheduler #(.FLUSH_CYCLES(FC), .MAX_OUTSTANDING(MO)) dut (
        .clk              (clk),
        .reset            (reset),
        .dec_valid        (dec_valid),
        .decoded_inst0    (decoded_inst0),
        .decoded_inst0_pc (decoded_inst0_pc),
        .ex_ready         (ex_ready),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .redirect_valid   (redirect_valid),
        .stall            (stall),
        .kill             (kill),
        .issue_valid      (issue_valid),
        .issue_inst       (issue_inst),
        .issue_pc         (issue_pc),
        .sb_busy          (sb_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: registers with an issued-but-unretired writer, and cycles of kill left.
    int q[$];
    int kill_left = 0;

    logic        last_iss, last_stall, last_kill;
    logic [31:0] last_sb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] uses(input logic [6:0] op); // {rs1, rs2, rd}
        case (op)
            OP:                 return 3'b111;
            LOAD, OP_IMM, JALR: return 3'b101;
            STORE, BRANCH:      return 3'b110;
            LUI, JAL:           return 3'b001;
            default:            return 3'b000;
        endcase
    endfunction

    function automatic logic in_q(input int r);
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_sb();
        logic [31:0] s = '0;
        foreach (q[i]) s[q[i]] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        decoded_inst_t d;
        d.opcode = op;
        d.rd     = 5'(rd);
        d.rs1    = 5'(rs1);
        d.rs2    = 5'(rs2);
        d.funct3 = 3'($urandom);
        d.funct7 = 7'($urandom);
        d.imm    = $urandom;
        return d;
    endfunction

    task automatic step(input logic dv, input logic [63:0] inst, input logic exr,
                        input logic wv, input int wr, input logic rv);
        decoded_inst_t d;
        logic [2:0]    u;
        logic          busy1, busy2, busyd, hz, writes, full, e_iss, e_stall;
        @(negedge clk);
        dec_valid        = dv;
        decoded_inst0    = inst;
        decoded_inst0_pc = $urandom;
        ex_ready         = exr;
        wb_valid         = wv;
        wb_rd            = 5'(wr);
        redirect_valid   = rv;
        #1;
        d      = inst;
        u      = uses(d.opcode);
        busy1  = in_q(int'(d.rs1)) && !(wv && wr == int'(d.rs1));
        busy2  = in_q(int'(d.rs2)) && !(wv && wr == int'(d.rs2));
        busyd  = in_q(int'(d.rd))  && !(wv && wr == int'(d.rd));
        hz     = (u[2] && busy1) || (u[1] && busy2) || (u[0] && busyd);
        writes = u[0] && d.rd != 5'd0;
        full   = writes && q.size() == int'(MO) && !wv;
        e_iss  = dv && kill_left == 0 && !rv && exr && !hz && !full;
        e_stall = kill_left == 0 && dv && !e_iss && !rv;
        chk("issue_valid", 64'(issue_valid), 64'(e_iss));
        chk("stall", 64'(stall), 64'(e_stall));
        chk("kill", 64'(kill), 64'(kill_left > 0));
        chk("sb_busy", 64'(sb_busy), 64'(model_sb()));
        if (e_iss) begin
            chk("issue_inst", issue_inst, inst);
            chk("issue_pc", 64'(issue_pc), 64'(decoded_inst0_pc));
        end
        last_iss   = issue_valid;
        last_stall = stall;
        last_kill  = kill;
        last_sb    = sb_busy;
        if (wv) begin
            foreach (q[i]) if (q[i] == wr) begin q.delete(i); break; end
        end
        if (e_iss && writes) q.push_back(int'(d.rd));
        if (rv) kill_left = int'(FC);
        else if (kill_left > 0) kill_left--;
    endtask

    logic [63:0] nop;
    logic [6:0]  ops [9];

    initial begin
        ops = '{OP, OP_IMM, LOAD, STORE, BRANCH, LUI, JAL, JALR, 7'b0001111};
        nop = '0;
        reset = 1'b1;
        dec_valid = 1'b0; decoded_inst0 = '0; decoded_inst0_pc = '0;
        ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; redirect_valid = 1'b0;
        #12;
        chk("reset_sb", 64'(sb_busy), 64'd0);
        chk("reset_kill", 64'(kill), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step(0, nop, 1, 0, 0, 0);
        step(0, nop, 0, 0, 0, 0);

        // RAW hazard on x3
        step(1, mk(OP, 3, 1, 2), 1, 0, 0, 0);
        chk("raw_first_issue", 64'(last_iss), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, mk(OP, 4, 3, 1), 1, 0, 0, 0);
            chk("raw_stall", 64'(last_stall), 64'd1);
        end
        step(1, mk(OP, 4, 3, 1), 1, 1, 3, 0);
        chk("raw_release_issue", 64'(last_iss), 64'd1);
        step(0, nop, 1, 1, 4, 0);

        // x0 and no-operand ops
        step(1, mk(LUI, 0, 0, 0), 1, 0, 0, 0);
        chk("lui_x0_issue", 64'(last_iss), 64'd1);
        step(1, mk(OP, 0, 0, 0), 1, 0, 0, 0);
        chk("x0_src_nostall", 64'(last_stall), 64'd0);
        step(1, mk(7'b0001111, 0, 0, 0), 1, 0, 0, 0);
        chk("x0_sb_zero", 64'(last_sb), 64'd0);

        // Redirect, then a second redirect extending kill
        step(1, mk(OP, 0, 0, 0), 1, 0, 0, 1);
        step(1, mk(OP, 0, 0, 0), 1, 0, 0, 0);
        chk("flush_kill1", 64'(last_kill), 64'd1);
        chk("flush_nostall", 64'(last_stall), 64'd0);
        step(1, mk(OP, 0, 0, 0), 1, 0, 0, 0);
        chk("flush_kill2", 64'(last_kill), 64'd1);
        step(1, mk(OP, 0, 0, 0), 1, 0, 0, 0);
        chk("flush_done_issue", 64'(last_iss), 64'd1);
        step(0, nop, 1, 0, 0, 1);
        step(0, nop, 1, 0, 0, 1);
        step(0, nop, 1, 0, 0, 0);
        step(0, nop, 1, 0, 0, 0);
        chk("flush_extended", 64'(last_kill), 64'd1);
        step(0, nop, 1, 0, 0, 0);
        chk("flush_ext_end", 64'(last_kill), 64'd0);

        // Outstanding limit
        for (int r = 5; r <= 8; r++) step(1, mk(OP_IMM, r, 0, 0), 1, 0, 0, 0);
        step(1, mk(OP_IMM, 11, 0, 0), 1, 0, 0, 0);
        chk("full_stall", 64'(last_stall), 64'd1);
        step(1, mk(OP_IMM, 11, 0, 0), 1, 1, 5, 0);
        chk("full_wb_issue", 64'(last_iss), 64'd1);
        step(1, mk(OP_IMM, 12, 0, 0), 1, 0, 0, 0);
        chk("still_full", 64'(last_iss), 64'd0);
        step(0, nop, 1, 1, 6, 0);
        step(0, nop, 1, 1, 7, 0);
        step(0, nop, 1, 1, 8, 0);
        step(0, nop, 1, 1, 11, 0);

        // Set/clear collision on x9
        step(1, mk(OP_IMM, 9, 0, 0), 1, 0, 0, 0);
        step(1, mk(OP_IMM, 9, 0, 0), 1, 1, 9, 0);
        step(0, nop, 1, 0, 0, 0);
        chk("collision_sb9", 64'(last_sb[9]), 64'd1);

        // Async reset mid-flush with scoreboard nonzero
        step(1, mk(OP_IMM, 13, 0, 0), 1, 0, 0, 1);
        step(0, nop, 1, 0, 0, 0);
        #2;
        dec_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_sb", 64'(sb_busy), 64'd0);
        chk("rst_kill", 64'(kill), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_issue", 64'(issue_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        kill_left = 0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic dv, exr, wv, rv;
            int   wr;
            logic [63:0] ins;
            dv  = ($urandom_range(9) < 8);
            exr = ($urandom_range(3) != 0);
            rv  = ($urandom_range(31) == 0);
            wv  = (q.size() > 0) && ($urandom_range(2) == 0);
            wr  = wv ? q[$urandom_range(q.size() - 1)] : int'($urandom_range(31));
            ins = mk(ops[$urandom_range(8)], int'($urandom_range(15, 1)),
                     int'($urandom_range(15)), int'($urandom_range(15)));
            step(dv, ins, exr, wv, wr, rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
